if_id_skid_reg: RTL
===================

Name: if_id_skid_reg

Overview:
- Elastic IF/ID pipeline register between the fetch stage and the decode stage.
- Captures each fetch bundle: instruction, pc, pc+4, pc+imme, jalr prediction/pc, and B-type prediction bit.
- Presents the bundle to decode with a valid flag.
- A 2-entry skid buffer absorbs the one bundle still in flight when decode stalls, so the fetch stall path is taken from a register rather than through decode logic.

Parameters:
- XLEN, 32, datapath width of instruction and all pc fields.
- NOP, 32'h00000013, instruction driven to decode when no valid bundle is held (addi x0,x0,0).
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch bundle valid this cycle.
- in_ready  output  1  buffer can accept a bundle this cycle.
- instr_i  input  XLEN  fetched instruction.
- pc_i  input  XLEN  pc of the instruction.
- pc_add_4_i  input  XLEN  pc+4.
- pc_add_imme_i  input  XLEN  branch/jump target.
- jalr_pc_pred_i  input  XLEN  jalr predicted target, or pc for non-jalr.
- b_pred_i  input  1  B-type prediction result.
- PL_stall  input  1  decode cannot consume this cycle.
- PL_flush  input  1  discard all held bundles (misprediction rollback).
- valid_o  output  1  outputs hold a valid bundle.
- instr_o, pc_o, pc_add_4_o, pc_add_imme_o, jalr_pc_pred_o  output  XLEN each  held bundle fields.
- b_pred_o  output  1  held prediction bit.
- occupancy  output  2  number of held bundles, 0..2.
- bubble_cnt  output  CNT_W  saturating count of bubble cycles.

Behaviour:
- Storage:
  - Main register M drives the outputs; skid register S sits behind it.
  - State is encoded by occupancy: EMPTY=0, ONE=1 (M valid), FULL=2 (M and S valid).
- Combinational control signals:
  - in_ready = (occupancy != 2). Depends on state only, never on in_valid or PL_stall.
  - accept = in_valid && in_ready && !PL_flush.
  - advance = valid_o && !PL_stall.
- Transitions (rising clk):
  - EMPTY: accept -> ONE, M<=in. Otherwise stay EMPTY.
  - ONE, accept && advance -> ONE, M<=in.
  - ONE, accept && !advance -> FULL, S<=in, M unchanged.
  - ONE, !accept && advance -> EMPTY.
  - ONE, neither -> hold.
  - FULL, advance -> ONE, M<=S. in_ready=0, so no accept is possible.
  - FULL, !advance -> hold.
- PL_flush: highest priority. Next state EMPTY from any state, S and M invalidated, the input bundle in that cycle is dropped. PL_flush && PL_stall together -> flush wins.
- Latency: 1 cycle from accept in EMPTY or ONE+advance to valid_o. Ordering is strictly FIFO; no bundle is dropped or duplicated except on flush.
- Output masking when valid_o=0:
  - instr_o=NOP.
  - pc_o, pc_add_4_o, pc_add_imme_o, jalr_pc_pred_o = 0.
  - b_pred_o=0.
  - Stored data is don't-care, but must not be visible on outputs.
- Field handling: all XLEN fields pass bit-exact; no arithmetic in this block.
- bubble_cnt: increments by 1 each cycle with valid_o=0 && PL_stall=0 && PL_flush=0. Saturates at 2^CNT_W-1, no wrap. Cleared only by reset.
- Reset (asynchronous, rst_n low): occupancy=0, valid_o=0, instr_o=NOP, all pc outputs 0, b_pred_o=0, bubble_cnt=0, in_ready=1. Reset mid-FULL discards both entries. First accept is possible on the first clk edge after rst_n deasserts.
- Registered outputs: every output except in_ready comes from a register or a fixed mux on the state.

Test Plan:
- Reset, then in_valid=1 with instr 0x00500093, pc 0x0 for 1 cycle, PL_stall=0 -> next cycle valid_o=1, instr_o=0x00500093, pc_o=0, pc_add_4_o=4; occupancy=1.
- Stream A (pc 0x0), then B (pc 0x4); PL_stall=1 in the cycle B arrives -> occupancy=2, in_ready=0, outputs still A. Release stall -> outputs B next cycle, occupancy=1, in_ready=1.
- FULL, then PL_flush=1 with in_valid=1 (C, pc 0x8) -> next cycle occupancy=0, valid_o=0, instr_o=0x00000013, pc_o=0; C never appears.
- PL_flush=1 and PL_stall=1 in the same cycle from ONE -> EMPTY next cycle. No input accepted that cycle.
- in_valid=0 for 70000 cycles, no stall/flush -> bubble_cnt=0xFFFF held. Assert rst_n=0 asynchronously mid-cycle -> bubble_cnt=0 immediately, with no clock edge.
- Random in_valid/PL_stall for 10k cycles with an incrementing-pc scoreboard -> pc_o sequence is strictly +4 per consumed bundle, no loss/duplication, occupancy never exceeds 2.

Source files
------------

// File: rtl/if_id_skid_reg_if.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg_if
// Bundles the fetch-side handshake and the decode-side bundle/status signals
// of the IF/ID elastic register so they travel as a single port.
//
// Signals:
//   fetch side  : in_valid, in_ready, instr_i, pc_i, pc_add_4_i,
//                 pc_add_imme_i, jalr_pc_pred_i, b_pred_i
//   decode side : PL_stall, PL_flush, valid_o, instr_o, pc_o, pc_add_4_o,
//                 pc_add_imme_o, jalr_pc_pred_o, b_pred_o
//   status      : occupancy (held bundles, 0..2), bubble_cnt
//
// Modports:
//   master : the fetch/decode environment driving the register
//   slave  : the IF/ID register itself
// ---------------------------------------------------------------------------
interface if_id_skid_reg_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  instr_i;
  logic [XLEN-1:0]  pc_i;
  logic [XLEN-1:0]  pc_add_4_i;
  logic [XLEN-1:0]  pc_add_imme_i;
  logic [XLEN-1:0]  jalr_pc_pred_i;
  logic             b_pred_i;

  logic             PL_stall;
  logic             PL_flush;

  logic             valid_o;
  logic [XLEN-1:0]  instr_o;
  logic [XLEN-1:0]  pc_o;
  logic [XLEN-1:0]  pc_add_4_o;
  logic [XLEN-1:0]  pc_add_imme_o;
  logic [XLEN-1:0]  jalr_pc_pred_o;
  logic             b_pred_o;

  logic [1:0]       occupancy;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output in_valid, instr_i, pc_i, pc_add_4_i, pc_add_imme_i,
           jalr_pc_pred_i, b_pred_i, PL_stall, PL_flush,
    input  in_ready, valid_o, instr_o, pc_o, pc_add_4_o, pc_add_imme_o,
           jalr_pc_pred_o, b_pred_o, occupancy, bubble_cnt
  );

  modport slave (
    input  in_valid, instr_i, pc_i, pc_add_4_i, pc_add_imme_i,
           jalr_pc_pred_i, b_pred_i, PL_stall, PL_flush,
    output in_ready, valid_o, instr_o, pc_o, pc_add_4_o, pc_add_imme_o,
           jalr_pc_pred_o, b_pred_o, occupancy, bubble_cnt
  );

endinterface

// File: rtl/if_id_skid_reg.sv
// ---------------------------------------------------------------------------
// if_id_skid_reg
// Elastic IF/ID pipeline register. A main register M feeds decode; a skid
// register S behind it catches the one bundle still in flight when decode
// stalls. Because in_ready depends only on the held count, the fetch stall
// path starts at a flop instead of running through decode logic.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : if_id_skid_reg_if.slave
//            - fetch bundle in  (in_valid/in_ready + instr/pc fields)
//            - decode control   (PL_stall, PL_flush)
//            - bundle out       (valid_o + instr/pc fields, masked when empty)
//            - status           (occupancy, saturating bubble_cnt)
// ---------------------------------------------------------------------------
module if_id_skid_reg #(
  parameter int              XLEN  = 32,
  parameter logic [XLEN-1:0] NOP   = 32'h00000013,
  parameter int              CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  if_id_skid_reg_if.slave   bus
);

  // The state value doubles as the held-bundle count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_add_4;
    logic [XLEN-1:0] pc_add_imme;
    logic [XLEN-1:0] jalr_pc_pred;
    logic            b_pred;
  } bundle_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  bundle_t          m_q, m_d;
  bundle_t          s_q, s_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  bundle_t          in_bundle;
  logic             valid;
  logic             ready;
  logic             accept;
  logic             advance;

  // Incoming fetch bundle gathered into one record.
  always_comb begin
    in_bundle.instr        = bus.instr_i;
    in_bundle.pc           = bus.pc_i;
    in_bundle.pc_add_4     = bus.pc_add_4_i;
    in_bundle.pc_add_imme  = bus.pc_add_imme_i;
    in_bundle.jalr_pc_pred = bus.jalr_pc_pred_i;
    in_bundle.b_pred       = bus.b_pred_i;
  end

  // Handshake qualifiers. ready is a function of state only, so fetch never
  // sees a combinational path from in_valid or PL_stall.
  always_comb begin
    valid   = (state_q != EMPTY);
    ready   = (state_q != FULL);
    accept  = bus.in_valid && ready && !bus.PL_flush;
    advance = valid && !bus.PL_stall;
  end

  // Next-state and data-movement logic. Flush overrides everything, including
  // a simultaneous stall, and drops the bundle offered in that cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    if (bus.PL_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_bundle;
          end
        end
        ONE: begin
          if (accept && advance) begin
            m_d = in_bundle;
          end else if (accept) begin
            state_d = FULL;
            s_d     = in_bundle;
          end else if (advance) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // ready is low here, so the only move is S shifting into M.
          if (advance) begin
            state_d = ONE;
            m_d     = s_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Bubble counter: counts cycles decode was free to consume but had nothing
  // valid, and sticks at its maximum instead of wrapping.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!valid && !bus.PL_stall && !bus.PL_flush && (bubble_cnt_q != CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Bundle storage. Contents are reset so no stale value is ever visible,
  // although the output mask already hides them while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

  // Outputs: a fixed mux on the registered state selects M or the idle
  // pattern (NOP instruction, zero pcs).
  assign bus.in_ready       = ready;
  assign bus.valid_o        = valid;
  assign bus.instr_o        = valid ? m_q.instr        : NOP;
  assign bus.pc_o           = valid ? m_q.pc           : '0;
  assign bus.pc_add_4_o     = valid ? m_q.pc_add_4     : '0;
  assign bus.pc_add_imme_o  = valid ? m_q.pc_add_imme  : '0;
  assign bus.jalr_pc_pred_o = valid ? m_q.jalr_pc_pred : '0;
  assign bus.b_pred_o       = valid ? m_q.b_pred       : 1'b0;
  assign bus.occupancy      = state_q;
  assign bus.bubble_cnt     = bubble_cnt_q;

endmodule
